// File: rtl/xgriscv_mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter.
package xgriscv_mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUS  = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ARB_IDLE,
    S_BUS  = ARB_BUS,
    S_RESP = ARB_RESP
  } arb_state_t;

  // Owner of the transaction in flight.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // A store with no enabled bytes completes without touching the bus.
  function automatic logic is_nop_store(input logic we, input logic [3:0] amp);
    return we && (amp == 4'b0000);
  endfunction

endpackage

// File: rtl/xgriscv_mem_arbiter_if.sv
// Pipeline-port and memory-bus signal bundle for the arbiter.
interface xgriscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_amp;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              bus_req;
  logic              bus_we;
  logic [3:0]        bus_be;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  logic              busy;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_amp, dm_addr, dm_wdata,
           bus_rdata, bus_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready,
           bus_req, bus_we, bus_be, bus_addr, bus_wdata, busy
  );

  // Pipeline + memory side.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_amp, dm_addr, dm_wdata,
           bus_rdata, bus_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
           bus_req, bus_we, bus_be, bus_addr, bus_wdata, busy
  );
endinterface

// File: rtl/xgriscv_arb_pick.sv
// Winner selection with a fetch-starvation guard: data wins ties until it
// has taken STARVE_MAX grants in a row while fetch was waiting.
module xgriscv_arb_pick
  import xgriscv_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_if_req,
  input  logic i_dm_req,
  input  logic i_grant,
  output logic o_owner
);
  localparam int            SW   = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] r_streak;
  logic          w_starved;

  assign w_starved = (r_streak == SMAX);
  assign o_owner   = (i_if_req && (!i_dm_req || w_starved)) ? OWN_I : OWN_D;

  // Count data grants that made fetch wait; saturate at SMAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_streak <= '0;
    end else if (i_grant) begin
      if (o_owner == OWN_I || !i_if_req) r_streak <= '0;
      else if (!w_starved)               r_streak <= r_streak + 1'b1;
    end
  end
endmodule

// File: rtl/xgriscv_mem_arbiter.sv
// Shares one variable-latency memory bus between instruction fetch and
// data access. IDLE arbitrates and latches, BUS holds the request until ack,
// RESP pulses the owner's ready for one cycle.
module xgriscv_mem_arbiter
  import xgriscv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                  clk,
  input logic                  reset,
  xgriscv_mem_arbiter_if.slave bus
);
  arb_state_t        r_state;
  logic              r_own;
  logic              r_we;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_bus_req;
  logic              r_if_ready, r_dm_ready;
  logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;

  logic w_grant, w_owner, w_nop;

  assign w_grant = (r_state == S_IDLE) && (bus.if_req || bus.dm_req);
  assign w_nop   = (w_owner == OWN_D) && is_nop_store(bus.dm_we, bus.dm_amp);

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_we;
  assign bus.bus_be    = r_be;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_wdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.dm_ready  = r_dm_ready;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.busy      = (r_state != S_IDLE);

  xgriscv_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk      (clk),
    .reset    (reset),
    .i_if_req (bus.if_req),
    .i_dm_req (bus.dm_req),
    .i_grant  (w_grant),
    .o_owner  (w_owner)
  );

  // Transaction FSM; every bus/port output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_own      <= OWN_I;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_bus_req  <= 1'b0;
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_own <= w_owner;
          if (w_owner == OWN_D) begin
            r_addr  <= bus.dm_addr;
            r_we    <= bus.dm_we;
            r_be    <= bus.dm_we ? bus.dm_amp : BE_ALL;
            r_wdata <= bus.dm_wdata;
          end else begin
            r_addr  <= bus.if_addr;
            r_we    <= 1'b0;
            r_be    <= BE_ALL;
          end
          if (w_nop) begin
            r_state    <= S_RESP;
            r_dm_ready <= 1'b1;
          end else begin
            r_state   <= S_BUS;
            r_bus_req <= 1'b1;
          end
        end
        S_BUS: if (bus.bus_ack) begin
          r_bus_req <= 1'b0;
          r_state   <= S_RESP;
          if (r_own == OWN_D) begin
            r_dm_ready <= 1'b1;
            if (!r_we) r_dm_rdata <= bus.bus_rdata;
          end else begin
            r_if_ready <= 1'b1;
            r_if_rdata <= bus.bus_rdata;
          end
        end
        S_RESP: begin
          r_if_ready <= 1'b0;
          r_dm_ready <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
